mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit with HI/LO registers for a MIPS-style E stage.
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-low
//   req        in   1   E-stage instruction valid this cycle
//   HILOType   in   4   mult=0 multu=1 div=2 divu=3 mfhi=4 mflo=5
//                       mthi=6 mtlo=7 none=15
//   A, B       in  32   rs / rt operands (already forwarded)
//   start      out  1   combinational: a mult/multu/div/divu is accepted now
//   busy       out  1   registered: an operation is in flight
//   HILO_out   out 32   combinational mfhi/mflo result
//   HI, LO     out 32   current HI/LO contents
//   state_dbg  out  2   FSM state (0=IDLE, 1=MUL, 2=DIV)
//
// Handshake: an md op is taken in any cycle where req=1, the op is 0..3 and
// busy=0; that cycle is the start cycle. The op then occupies 5 (mul) or
// 10 (div) busy cycles, during which further md/mt requests are dropped.
// HI/LO change on the edge that ends the last busy cycle.
// ---------------------------------------------------------------------------
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  HILOType,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HILO_out,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        uns_q, uns_d;    // unsigned variant (multu/divu)
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    // Datapath, evaluated from the latched operands only
    logic [63:0] a_ext, b_ext, product;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b, divisor, q_mag, r_mag, quo, rem;

    always_comb begin
        // Sign-extend for mult; the low 64 bits of the product of the
        // extended operands are the exact signed product.
        a_ext   = uns_q ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
        b_ext   = uns_q ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
        product = a_ext * b_ext;

        // Signed division via magnitudes. This also covers
        // 0x80000000 / -1: magnitude 0x80000000, sign positive, wraps to
        // 0x80000000 with remainder 0.
        a_neg   = ~uns_q & a_q[31];
        b_neg   = ~uns_q & b_q[31];
        abs_a   = a_neg ? (32'd0 - a_q) : a_q;
        abs_b   = b_neg ? (32'd0 - b_q) : b_q;
        // Divide-by-zero never commits, the guard only keeps the operator sane
        divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag   = abs_a / divisor;
        r_mag   = abs_a % divisor;
        quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    assign start = req & (HILOType[3:2] == 2'b00) & ~busy_q & reset;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        uns_d   = uns_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        if (start) begin
            a_d    = A;
            b_d    = B;
            uns_d  = HILOType[0];
            busy_d = 1'b1;
            if (HILOType[1]) begin
                state_d = DIV;
                count_d = 4'd10;
            end else begin
                state_d = MUL;
                count_d = 4'd5;
            end
        end else if (state_q != IDLE) begin
            if (count_q == 4'd1) begin
                state_d = IDLE;
                count_d = 4'd0;
                busy_d  = 1'b0;
                if (state_q == MUL) begin
                    hi_d = product[63:32];
                    lo_d = product[31:0];
                end else if (b_q != 32'd0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end else begin
                count_d = count_q - 4'd1;
            end
        end else if (req && !busy_q) begin
            if (HILOType == 4'd6) begin
                hi_d = A;
            end else if (HILOType == 4'd7) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            uns_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            uns_q   <= uns_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        HILO_out = 32'd0;
        if (HILOType == 4'd4) begin
            HILO_out = hi_q;
        end else if (HILOType == 4'd5) begin
            HILO_out = lo_q;
        end
    end

    assign busy      = busy_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign state_dbg = state_q;

endmodule
